// File: rtl/issue_buffer_pkg.sv
// Shared helpers for the multi-lane issue buffer: lane prefix counting and
// pointer/count width helpers derived from the buffer depth.
package issue_buffer_pkg;

   localparam int unsigned MaxPorts = 4;

   // Number of consecutive ones starting at bit 0.
   function automatic int unsigned prefix_ones(input logic [MaxPorts-1:0] vec);
      int unsigned n;
      logic        run;
      n   = 0;
      run = 1'b1;
      for (int i = 0; i < MaxPorts; i++) begin
         run = run & vec[i];
         if (run) n = n + 1;
      end
      return n;
   endfunction

   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/issue_buffer_ram.sv
// Entry storage: NrPorts write ports on the clock edge, NrPorts asynchronous
// read ports, no reset.
module issue_buffer_ram
   import issue_buffer_pkg::*;
#(
   parameter int unsigned NrPorts   = 2,
   parameter int unsigned Depth     = 8,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned AddrW     = ptr_width(Depth)
) (
   input  logic                           clk_i,
   input  logic [NrPorts-1:0]             we_i,
   input  logic [NrPorts*AddrW-1:0]       waddr_i,
   input  logic [NrPorts*DataWidth-1:0]   wdata_i,
   input  logic [NrPorts*AddrW-1:0]       raddr_i,
   output logic [NrPorts*DataWidth-1:0]   rdata_o
);

   logic [DataWidth-1:0] mem [Depth];

   // Write addresses within one cycle are always distinct lanes of a contiguous run.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NrPorts; k++) begin
         if (we_i[k]) mem[waddr_i[k*AddrW +: AddrW]] <= wdata_i[k*DataWidth +: DataWidth];
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int k = 0; k < NrPorts; k++) begin
         rdata_o[k*DataWidth +: DataWidth] = mem[raddr_i[k*AddrW +: AddrW]];
      end
   end

endmodule

// File: rtl/issue_buffer_mp.sv
// Multi-lane in-order buffer between decode and issue: up to NrPorts pushes and
// pops per cycle, occupancy flags and single-cycle flush of unissued entries.
module issue_buffer_mp
   import issue_buffer_pkg::*;
#(
   parameter int unsigned NrPorts          = 2,
   parameter int unsigned Depth            = 8,
   parameter int unsigned DataWidth        = 64,
   parameter int unsigned AlmostFullThresh = 6
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic                           stall_i,
   input  logic [NrPorts*DataWidth-1:0]   data_i,
   input  logic [NrPorts-1:0]             valid_i,
   output logic [NrPorts-1:0]             ack_o,
   output logic [NrPorts*DataWidth-1:0]   data_o,
   output logic [NrPorts-1:0]             valid_o,
   input  logic [NrPorts-1:0]             ready_i,
   output logic [$clog2(Depth):0]         count_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic                           almost_full_o
);

   localparam int unsigned PtrW = ptr_width(Depth);
   localparam int unsigned CntW = cnt_width(Depth);

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;

   ptr_t rd_ptr_q, wr_ptr_q;
   cnt_t count_q;
   cnt_t n_push, n_pop;

   logic [NrPorts-1:0]           pop;
   logic [NrPorts*PtrW-1:0]      waddr, raddr;
   logic [NrPorts*DataWidth-1:0] rdata;

   issue_buffer_ram #(
      .NrPorts   (NrPorts),
      .Depth     (Depth),
      .DataWidth (DataWidth),
      .AddrW     (PtrW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ack_o),
      .waddr_i (waddr),
      .wdata_i (data_i),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   // Handshakes use only registered count; ready_i never reaches ack_o.
   always_comb begin
      ack_o   = '0;
      valid_o = '0;
      data_o  = '0;
      pop     = '0;
      waddr   = '0;
      raddr   = '0;
      for (int k = 0; k < NrPorts; k++) begin
         waddr[k*PtrW +: PtrW] = wr_ptr_q + ptr_t'(k);
         raddr[k*PtrW +: PtrW] = rd_ptr_q + ptr_t'(k);
         ack_o[k]   = valid_i[k] && (32'(count_q) + 32'(k) < Depth) && !flush_i && !rst_i;
         valid_o[k] = (32'(count_q) > 32'(k)) && !stall_i && !flush_i;
         if (valid_o[k]) data_o[k*DataWidth +: DataWidth] = rdata[k*DataWidth +: DataWidth];
         pop[k] = valid_o[k] & ready_i[k];
      end
      n_push = cnt_t'(prefix_ones(MaxPorts'(ack_o)));
      n_pop  = cnt_t'(prefix_ones(MaxPorts'(pop)));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_q + ptr_t'(n_pop);
         wr_ptr_q <= wr_ptr_q + ptr_t'(n_push);
         count_q  <= count_q + n_push - n_pop;
      end
   end

   assign count_o       = count_q;
   assign full_o        = (count_q == cnt_t'(Depth));
   assign empty_o       = (count_q == '0);
   assign almost_full_o = (32'(count_q) >= AlmostFullThresh);

   count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= cnt_t'(Depth));

endmodule

// File: doc/issue_buffer_mp.md
Name: issue_buffer_mp

Overview:
- Parametrised multi-lane in-order instruction buffer between the decode and issue stages.
- Decouples decode from scoreboard/issue backpressure.
- Accepts up to NrPorts entries per cycle and releases up to NrPorts entries per cycle, in program order.
- Adds occupancy reporting, an almost-full watermark, and a single-cycle flush of unissued entries, none of which a direct decode-to-issue handshake has.

Parameters:
- NrPorts, 2, number of enqueue lanes and number of dequeue lanes (1..4).
- Depth, 8, entry count; power of 2, >= 2*NrPorts.
- DataWidth, 64, payload width per entry (packed scoreboard entry plus original instruction).
- AlmostFullThresh, 6, occupancy at or above which almost_full_o asserts (< Depth).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  drop all buffered entries (flush of unissued instructions).
- stall_i  in  1  block dequeue (accelerator dispatcher stall).
- data_i  in  NrPorts*DataWidth  enqueue payload; lane 0 is oldest.
- valid_i  in  NrPorts  enqueue valid per lane.
- ack_o  out  NrPorts  enqueue accepted per lane.
- data_o  out  NrPorts*DataWidth  dequeue payload; lane 0 is oldest.
- valid_o  out  NrPorts  dequeue valid per lane.
- ready_i  in  NrPorts  consumer ready per lane.
- count_o  out  $clog2(Depth)+1  current occupancy.
- full_o  out  1  count_o == Depth.
- empty_o  out  1  count_o == 0.
- almost_full_o  out  1  count_o >= AlmostFullThresh.

Behaviour:
- State: storage array, rd_ptr and wr_ptr ($clog2(Depth) bits, wrap modulo Depth), count register.
- Reset (rst_i high at a clock edge): rd_ptr, wr_ptr and count go to 0. Storage is not reset.
  - Following cycle: valid_o=0, data_o=0, count_o=0, empty_o=1, full_o=0, almost_full_o=0.
  - ack_o is 0 while rst_i is high.
  - Reset mid-operation discards all contents; no entry reappears.
- Enqueue:
  - Producer guarantees valid_i is a contiguous prefix from lane 0; behaviour is undefined otherwise, and the bench asserts the rule.
  - ack_o[k] = valid_i[k] & (Depth - count > k) & !flush_i & !rst_i.
  - ack_o depends only on registered count; there is no combinational path from ready_i.
  - Accepted lanes are written at wr_ptr+k. wr_ptr advances by the number accepted.
- Dequeue:
  - valid_o[k] = (count > k) & !stall_i & !flush_i.
  - data_o[k] = storage[rd_ptr+k] when valid_o[k], else 0.
  - Lane k pops only if valid_o[j] & ready_i[j] for every j <= k (prefix rule). A ready lane above a non-ready lane is ignored.
  - rd_ptr advances by the pop count.
- Latency:
  - Enqueue to visible on valid_o is 1 cycle minimum. There is no bypass, even when empty.
  - A pop frees its slot for ack_o on the next cycle only.
- Count update: count_next = count + pushes - pops; simultaneous push and pop is allowed.
  - count never exceeds Depth; a violation is an assertion failure.
- Flush:
  - ack_o=0 and valid_o=0 in the flush cycle, so nothing pops and nothing is accepted.
  - Next cycle: count=0, rd_ptr=wr_ptr=0.
  - rst_i has priority over flush_i.
- Stall: contents unchanged and enqueue continues until full.
- Wrap-around: a multi-lane push or pop straddling index Depth-1 to 0 handles each lane modulo Depth.
- Order: strict FIFO across lanes and cycles.

Decomposition:
- issue_buffer_pkg holds:
  - function prefix_ones(vec) → number of leading consecutive ones from bit 0 (used for pop count and push count);
  - ptr_t and cnt_t width helpers parameterised by Depth.
- Storage sub-module issue_buffer_ram: NrPorts write ports and NrPorts read ports, asynchronous read, write on clock edge, no reset.
- Top level holds pointers, count, handshake logic and status flags.

Test Plan (NrPorts=2, Depth=8, DataWidth=32, AlmostFullThresh=6):
1. Reset then push A,B in one cycle (valid_i=11) → ack_o=11. Next cycle valid_o=11, data_o={B,A}, count_o=2.
2. Fill with 4 cycles of valid_i=11 and ready_i=00 → count_o reaches 8 and full_o=1. almost_full_o rises when count_o=6. A 5th push gets ack_o=00. With count 7 and valid_i=11 → ack_o=01.
3. Partial pop with count 3 and ready_i=10 → no pop, count stays 3. Then ready_i=01 → pops lane 0 only, count 2, and the next data_o[0] is the former lane 1.
4. Wrap: with rd_ptr=wr_ptr=7, push X,Y → stored at slots 7 and 0. Next cycle data_o={Y,X}. Pop both → rd_ptr=1, empty_o=1.
5. Flush with count 5 while valid_i=11 → ack_o=00 and valid_o=00 that cycle. Next cycle count_o=0 and empty_o=1. Then push Z → Z appears on lane 0 one cycle later.
6. stall_i=1 with count 4 and ready_i=11 for 3 cycles → valid_o=00 and count holds at 4. Release → 2 entries pop per cycle in order. Assert rst_i with count 4 → next cycle count_o=0 and valid_o=00.
